// File: rtl/cola_destinos_fifo.sv
// Hall-call destination queue: circular FIFO of floor codes with duplicate
// suppression, drop flagging on invalid/full pushes, and a pending-floor bitmap.
module cola_destinos_fifo #(
   parameter int FLOOR_W    = 2,
   parameter int NUM_FLOORS = 4,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  limpiar,
   input  logic                  push,
   input  logic [FLOOR_W-1:0]    piso_in,
   input  logic                  pop,
   output logic [FLOOR_W-1:0]    destino,
   output logic                  valido,
   output logic                  lleno,
   output logic [CNT_W-1:0]      cuenta,
   output logic [NUM_FLOORS-1:0] pendientes,
   output logic                  descartado
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [FLOOR_W-1:0]    mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr, wr_ptr, rd_nxt, wr_nxt;
   logic [CNT_W-1:0]      cnt_nxt;
   logic [NUM_FLOORS-1:0] pend_nxt, sel_in, sel_head, sel_pop;
   logic [FLOOR_W-1:0]    head_nxt;
   logic                  in_range, dup, pop_eff, room, push_ok;

   always_comb begin
      sel_in   = '0;
      sel_head = '0;
      // One-hot decode doubles as the range check: codes >= NUM_FLOORS decode to zero
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
         if (piso_in == FLOOR_W'(i)) sel_in[i] = 1'b1;
         if (destino == FLOOR_W'(i)) sel_head[i] = 1'b1;
      end
      in_range = (sel_in != '0);
      pop_eff  = pop && valido;
      sel_pop  = pop_eff ? sel_head : '0;
      dup      = |(sel_in & pendientes & ~sel_pop);
      room     = !lleno || pop_eff;
      push_ok  = push && in_range && !dup && room;

      rd_nxt   = pop_eff ? rd_ptr + PTR_W'(1) : rd_ptr;
      wr_nxt   = push_ok ? wr_ptr + PTR_W'(1) : wr_ptr;
      pend_nxt = (pendientes & ~sel_pop) | (push_ok ? sel_in : '0);

      cnt_nxt = cuenta;
      if (push_ok && !pop_eff)
         cnt_nxt = cuenta + CNT_W'(1);
      else if (pop_eff && !push_ok)
         cnt_nxt = cuenta - CNT_W'(1);

      // The entry being written this cycle becomes head when it lands at the new read pointer
      if (cnt_nxt == '0)
         head_nxt = '0;
      else if (push_ok && (wr_ptr == rd_nxt))
         head_nxt = piso_in;
      else
         head_nxt = mem[rd_nxt];
   end

   always_ff @(posedge clk) begin
      if (!reset && !limpiar && push_ok)
         mem[wr_ptr] <= piso_in;
   end

   always_ff @(posedge clk) begin
      if (reset || limpiar) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         cuenta     <= '0;
         pendientes <= '0;
         destino    <= '0;
         valido     <= 1'b0;
         lleno      <= 1'b0;
         descartado <= 1'b0;
      end else begin
         rd_ptr     <= rd_nxt;
         wr_ptr     <= wr_nxt;
         cuenta     <= cnt_nxt;
         pendientes <= pend_nxt;
         destino    <= head_nxt;
         valido     <= (cnt_nxt != '0);
         lleno      <= (cnt_nxt == CNT_W'(DEPTH));
         descartado <= push && !push_ok;
      end
   end

endmodule
